// File: rtl/vga_bg_fetch.sv
// Background word fetcher for the VGA pipeline.
//
// At the end of each active line (falling edge of h_active) the row/line
// counters advance and, if no fetch is in flight, a three-word read is issued
// for the background row that the next line will display. The three words are
// two pixel words and one word holding the two pixel-size fields. If the fetch
// completes during horizontal blank, the committed outputs all update at once.
// If it completes after the next line has already started, the fetch is
// dropped and the sticky underrun flag is raised.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   h_active, v_active    video timing windows
//   bg_base               word address of background row 0
//   bg_row_repeat         each background row is shown for bg_row_repeat+1 lines
//   underrun_clr          clears underrun (a same-cycle set takes priority)
//   mem_req, mem_addr     read request / word address, held until mem_ack
//   mem_ack, mem_data     read accept; data valid in the ack cycle
//   bg_pixels_0/1         committed pixel words
//   bg_size_0/1           committed pixel-size values
//   underrun              sticky late-fetch flag
module vga_bg_fetch (
    input  logic        clk,
    input  logic        reset,
    input  logic        h_active,
    input  logic        v_active,
    input  logic [7:0]  bg_base,
    input  logic [5:0]  bg_row_repeat,
    input  logic        underrun_clr,
    output logic        mem_req,
    output logic [7:0]  mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_data,
    output logic [31:0] bg_pixels_0,
    output logic [31:0] bg_pixels_1,
    output logic [5:0]  bg_size_0,
    output logic [5:0]  bg_size_1,
    output logic        underrun
);

    typedef enum logic [1:0] {StIdle, StW0, StW1, StW2} state_e;

    state_e      state_q;
    logic        h_active_d;
    logic [5:0]  row_q;
    logic [5:0]  line_q;
    logic [7:0]  fetch_base_q;
    logic [31:0] stage_pix0_q;
    logic [31:0] stage_pix1_q;

    logic        trigger;
    logic        late_set;
    logic [5:0]  target_row;
    logic [7:0]  target_base;

    assign trigger  = h_active_d & ~h_active;
    assign late_set = (state_q == StW2) & mem_ack & h_active;

    // Row the next line will show, evaluated against the pre-update counters.
    always_comb begin
        target_row = row_q;
        if (!v_active) begin
            target_row = 6'd0;
        end else if (line_q == bg_row_repeat) begin
            target_row = row_q + 6'd1;
        end
    end

    // base + 3*row, mod 256; 3*63 still fits in 8 bits before the add.
    assign target_base = bg_base + {2'b00, target_row} + {1'b0, target_row, 1'b0};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            h_active_d   <= 1'b0;
            row_q        <= 6'd0;
            line_q       <= 6'd0;
            fetch_base_q <= 8'd0;
            stage_pix0_q <= 32'd0;
            stage_pix1_q <= 32'd0;
            mem_req      <= 1'b0;
            mem_addr     <= 8'd0;
            bg_pixels_0  <= 32'd0;
            bg_pixels_1  <= 32'd0;
            bg_size_0    <= 6'd0;
            bg_size_1    <= 6'd0;
            underrun     <= 1'b0;
        end else begin
            h_active_d <= h_active;

            // Counters follow every line end, even while a fetch is in flight.
            if (trigger) begin
                if (!v_active) begin
                    row_q  <= 6'd0;
                    line_q <= 6'd0;
                end else if (line_q == bg_row_repeat) begin
                    row_q  <= row_q + 6'd1;
                    line_q <= 6'd0;
                end else begin
                    line_q <= line_q + 6'd1;
                end
            end

            case (state_q)
                StIdle: begin
                    if (trigger) begin
                        state_q      <= StW0;
                        mem_req      <= 1'b1;
                        mem_addr     <= target_base;
                        fetch_base_q <= target_base;
                    end
                end
                StW0: begin
                    if (mem_ack) begin
                        stage_pix0_q <= mem_data;
                        mem_addr     <= fetch_base_q + 8'd1;
                        state_q      <= StW1;
                    end
                end
                StW1: begin
                    if (mem_ack) begin
                        stage_pix1_q <= mem_data;
                        mem_addr     <= fetch_base_q + 8'd2;
                        state_q      <= StW2;
                    end
                end
                StW2: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state_q <= StIdle;
                        // A late fetch leaves the committed outputs untouched.
                        if (!h_active) begin
                            bg_pixels_0 <= stage_pix0_q;
                            bg_pixels_1 <= stage_pix1_q;
                            bg_size_0   <= mem_data[5:0];
                            bg_size_1   <= mem_data[13:8];
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    mem_req <= 1'b0;
                end
            endcase

            if (late_set) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule

// File: doc/vga_bg_fetch.md
VGA_BG_FETCH -- requirements
Module: vga_bg_fetch

Interface
REQ-001 SHALL have clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL have h_active  input  1  horizontal active video window.
REQ-004 SHALL have v_active  input  1  vertical active video window.
REQ-005 SHALL have bg_base  input  8  memory word address of background row 0.
REQ-006 SHALL have bg_row_repeat  input  6  value R; each background row is displayed for R+1 scanlines.
REQ-007 SHALL have underrun_clr  input  1  clears the underrun flag.
REQ-008 SHALL have mem_req  output  1  memory read request.
REQ-009 SHALL have mem_addr  output  8  memory read word address.
REQ-010 SHALL have mem_ack  input  1  read accepted; mem_data valid in the same cycle.
REQ-011 SHALL have mem_data  input  32  read data.
REQ-012 SHALL have bg_pixels_0, bg_pixels_1  output  32 each  committed pixel words for the background datapath.
REQ-013 SHALL have bg_size_0, bg_size_1  output  6 each  committed pixel-size values.
REQ-014 SHALL have underrun  output  1  sticky late-fetch flag.

Function
REQ-015 SHALL register h_active into h_active_d; trigger = h_active_d & ~h_active (end of active line).
REQ-016 SHALL hold row counter (6 bits) and line counter (6 bits).
REQ-017 On trigger with v_active=0: row<=0, line<=0, fetch target row 0.
REQ-018 On trigger with v_active=1 and line==bg_row_repeat: line<=0, row<=row+1 (wraps 63->0), fetch target row+1 (wrapped).
REQ-019 On trigger with v_active=1 and line!=bg_row_repeat: line<=line+1, fetch target row.
REQ-020 SHALL latch the fetch target row at trigger; later changes to bg_base/bg_row_repeat affect only later fetches.
REQ-021 SHALL use FSM states IDLE, W0, W1, W2; IDLE->W0 on trigger; Wn->W(n+1) on mem_ack; W2->IDLE on mem_ack.
REQ-022 SHALL, in W0/W1/W2, set mem_addr = (bg_base + 3*target_row + n) mod 256 with n = 0/1/2.
REQ-023 SHALL assert mem_req in W0..W2 and only there, holding it and mem_addr stable until mem_ack; mem_req may remain high across words, with mem_addr changing in the cycle after ack.
REQ-024 SHALL store mem_data into staging: W0 -> pixels_0, W1 -> pixels_1, W2 -> size_0 = data[5:0], size_1 = data[13:8]; other bits ignored.
REQ-025 SHALL commit on the W2 ack cycle when h_active=0: all four outputs load staged values at the next edge, simultaneously.
REQ-026 SHALL, on the W2 ack cycle with h_active=1 (fetch late): discard staging, leave outputs unchanged, set underrun.
REQ-027 SHALL ignore trigger while not IDLE; row/line counters still update per REQ-017..019, and the in-flight fetch completes with its original target.
REQ-028 SHALL never abort a request before mem_ack; mem_ack in IDLE is ignored.
REQ-029 underrun SHALL stay set until underrun_clr=1 or reset; set and clear in the same cycle -> set wins.
REQ-030 Latency: first mem_req rises the cycle after the trigger cycle; with zero-wait ack, outputs update 4 cycles after the trigger.

Reset
REQ-031 Reset SHALL set FSM=IDLE, mem_req=0, mem_addr=0, h_active_d=0, row=0, line=0, staging=0, bg_pixels_0/1=0, bg_size_0/1=0, underrun=0.
REQ-032 Reset mid-fetch SHALL drop mem_req the next cycle, with no commit and no underrun.

Verification
REQ-033 bg_base=0x10, v_active=0, h_active 1->0, ack each cycle, data A,B,0x0000_0203 -> addrs 0x10,0x11,0x12; pixels_0=A, pixels_1=B, size_0=3, size_1=2.
REQ-034 R=1, v_active=1, three line ends after the vblank fetch -> target rows 0,1,1 (addrs base+0, base+3, base+3).
REQ-035 Hold mem_ack low 5 cycles in W1 -> mem_req and mem_addr stable throughout; one capture only.
REQ-036 Delay the W2 ack past h_active rise -> outputs unchanged, underrun=1; underrun_clr pulse -> underrun=0.
REQ-037 bg_base=0xFE, row 21 -> addrs 0x3D,0x3E,0x3F; bg_base=0xFF, row 0 -> addrs 0xFF,0x00,0x01 (wrap).
REQ-038 Assert reset during W1 -> next cycle mem_req=0 and all outputs 0.
